// File: rtl/bin2bcd_seg_seq.sv
// bin2bcd_seg_seq: sequential double-dabble binary-to-BCD converter driving active-low 7-segment digits.
// Optional BCD_LEADING_ZERO_BLANK_EN blanks hex digits above the most significant nonzero digit.
module bin2bcd_seg_seq #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic                  ovf,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [7*DIGITS-1:0]   hex
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [6:0] DASH  = 7'h3F;
    localparam logic [6:0] BLANK = 7'h7F;

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t              state_q, state_d;
    logic [WIDTH-1:0]    op_q, op_d;
    logic [4*DIGITS-1:0] acc_q, acc_d, acc_adj, bcd_q, bcd_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                ovf_int_q, ovf_int_d, ovf_q, ovf_d, done_q, done_d;
    logic [7*DIGITS-1:0] hex_q, hex_d;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'h40;
            4'd1:    seg7 = 7'h79;
            4'd2:    seg7 = 7'h24;
            4'd3:    seg7 = 7'h30;
            4'd4:    seg7 = 7'h19;
            4'd5:    seg7 = 7'h12;
            4'd6:    seg7 = 7'h02;
            4'd7:    seg7 = 7'h78;
            4'd8:    seg7 = 7'h00;
            4'd9:    seg7 = 7'h10;
            default: seg7 = BLANK;
        endcase
    endfunction

    function automatic logic [7*DIGITS-1:0] render(input logic [4*DIGITS-1:0] b, input logic o);
        logic [7*DIGITS-1:0] r;
`ifdef BCD_LEADING_ZERO_BLANK_EN
        logic lead;
        lead = 1'b1;
`endif
        r = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
`ifdef BCD_LEADING_ZERO_BLANK_EN
            lead = lead && (b[4*i +: 4] == 4'd0) && (i != 0);
            r[7*i +: 7] = o ? DASH : lead ? BLANK : seg7(b[4*i +: 4]);
`else
            r[7*i +: 7] = o ? DASH : seg7(b[4*i +: 4]);
`endif
        end
        return r;
    endfunction

    always_comb begin
        acc_adj = acc_q;
        for (int i = 0; i < DIGITS; i++)
            acc_adj[4*i +: 4] = (acc_q[4*i +: 4] >= 4'd5) ? acc_q[4*i +: 4] + 4'd3 : acc_q[4*i +: 4];
    end

    // SHIFT runs WIDTH shift edges, then one extra edge (counter at zero) publishes the result
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        ovf_int_d = ovf_int_q;
        ovf_d     = ovf_q;
        bcd_d     = bcd_q;
        hex_d     = hex_q;
        done_d    = 1'b0;
        if (state_q == IDLE) begin
            if (start) begin
                op_d      = bin;
                acc_d     = '0;
                ovf_int_d = 1'b0;
                cnt_d     = CW'(WIDTH);
                state_d   = SHIFT;
            end
        end else if (cnt_q != '0) begin
            acc_d     = {acc_adj[4*DIGITS-2:0], op_q[WIDTH-1]};
            op_d      = op_q << 1;
            ovf_int_d = ovf_int_q | acc_adj[4*DIGITS-1];
            cnt_d     = cnt_q - 1'b1;
        end else begin
            bcd_d   = acc_q;
            ovf_d   = ovf_int_q;
            hex_d   = render(acc_q, ovf_int_q);
            done_d  = 1'b1;
            state_d = IDLE;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            op_q      <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            ovf_int_q <= 1'b0;
            ovf_q     <= 1'b0;
            done_q    <= 1'b0;
            bcd_q     <= '0;
            hex_q     <= render('0, 1'b0);
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            ovf_int_q <= ovf_int_d;
            ovf_q     <= ovf_d;
            done_q    <= done_d;
            bcd_q     <= bcd_d;
            hex_q     <= hex_d;
        end
    end

    assign busy = (state_q == SHIFT);
    assign done = done_q;
    assign ovf  = ovf_q;
    assign bcd  = bcd_q;
    assign hex  = hex_q;
endmodule

// File: tb/tb_bin2bcd_seg_seq.sv
// tb_bin2bcd_seg_seq: vector table, hand sequences and random/sweep checks against a value-level decimal model.
module tb_bin2bcd_seg_seq;
    logic        clock, resetn;
    logic        start_a, start_c;
    logic [7:0]  bin_a;
    logic [15:0] bin_c;
    logic        busy_a, done_a, ovf_a, busy_b, done_b, ovf_b, busy_c, done_c, ovf_c;
    logic [11:0] bcd_a;
    logic [20:0] hex_a;
    logic [7:0]  bcd_b;
    logic [13:0] hex_b;
    logic [19:0] bcd_c;
    logic [34:0] hex_c;

    int n_tests = 0;
    int n_fail  = 0;
    int lat, pulses;

    bin2bcd_seg_seq #(.WIDTH(8), .DIGITS(3)) dut (
        .clock(clock), .resetn(resetn), .start(start_a), .bin(bin_a),
        .busy(busy_a), .done(done_a), .ovf(ovf_a), .bcd(bcd_a), .hex(hex_a));
    bin2bcd_seg_seq #(.WIDTH(8), .DIGITS(2)) dut2 (
        .clock(clock), .resetn(resetn), .start(start_a), .bin(bin_a),
        .busy(busy_b), .done(done_b), .ovf(ovf_b), .bcd(bcd_b), .hex(hex_b));
    bin2bcd_seg_seq #(.WIDTH(16), .DIGITS(5)) dut5 (
        .clock(clock), .resetn(resetn), .start(start_c), .bin(bin_c),
        .busy(busy_c), .done(done_c), .ovf(ovf_c), .bcd(bcd_c), .hex(hex_c));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    function automatic int p10(input int n);
        int p = 1;
        for (int i = 0; i < n; i++) p *= 10;
        return p;
    endfunction

    function automatic logic [63:0] ref_bcd(input int v, input int n);
        logic [63:0] r = '0;
        int x = v;
        for (int i = 0; i < n; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x /= 10;
        end
        return r;
    endfunction

    function automatic logic [63:0] ref_hex(input int v, input int n);
        logic [63:0] r = '0;
        logic blank;
        for (int i = 0; i < n; i++) begin
`ifdef BCD_LEADING_ZERO_BLANK_EN
            blank = (i > 0) && (v < p10(i));
`else
            blank = 1'b0;
`endif
            if (v >= p10(n)) r[7*i +: 7] = 7'h3F;
            else r[7*i +: 7] = blank ? 7'h7F : seg_tab[(v / p10(i)) % 10];
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic run_a(input logic [7:0] v, output int l);
        bin_a = v;
        start_a = 1'b1;
        tick;
        start_a = 1'b0;
        l = 0;
        while (!done_a && l < 40) begin
            tick;
            l++;
        end
    endtask

    task automatic run_c(input logic [15:0] v, output int l);
        bin_c = v;
        start_c = 1'b1;
        tick;
        start_c = 1'b0;
        l = 0;
        while (!done_c && l < 60) begin
            tick;
            l++;
        end
    endtask

    task automatic check_a(input int v);
        check("bcd3", bcd_a, ref_bcd(v, 3));
        check("ovf3", ovf_a, v >= 1000);
        check("hex3", hex_a, ref_hex(v, 3));
        check("done2", done_b, 1);
        check("bcd2", bcd_b, ref_bcd(v, 2));
        check("ovf2", ovf_b, v >= 100);
        check("hex2", hex_b, ref_hex(v, 2));
    endtask

    typedef struct {
        logic [7:0]  bin;
        logic [11:0] bcd3;
        logic        ovf3;
        logic [7:0]  bcd2;
        logic        ovf2;
    } vec_t;
    vec_t vecs [8];

    initial begin
        vecs[0] = '{8'd255, 12'h255, 1'b0, 8'h55, 1'b1};
        vecs[1] = '{8'd0,   12'h000, 1'b0, 8'h00, 1'b0};
        vecs[2] = '{8'd100, 12'h100, 1'b0, 8'h00, 1'b1};
        vecs[3] = '{8'd99,  12'h099, 1'b0, 8'h99, 1'b0};
        vecs[4] = '{8'd42,  12'h042, 1'b0, 8'h42, 1'b0};
        vecs[5] = '{8'd9,   12'h009, 1'b0, 8'h09, 1'b0};
        vecs[6] = '{8'd10,  12'h010, 1'b0, 8'h10, 1'b0};
        vecs[7] = '{8'd200, 12'h200, 1'b0, 8'h00, 1'b1};

        resetn = 1'b0; start_a = 1'b0; start_c = 1'b0; bin_a = '0; bin_c = '0;
        repeat (2) tick;
        check("rst_busy", busy_a, 0);
        check("rst_done", done_a, 0);
        check("rst_ovf", ovf_a, 0);
        check("rst_bcd", bcd_a, 0);
        check("rst_hex", hex_a, ref_hex(0, 3));
        check("rst_hex5", hex_c, ref_hex(0, 5));
        #2 resetn = 1'b1;
        tick;

        for (int i = 0; i < 8; i++) begin
            run_a(vecs[i].bin, lat);
            check("lat", lat, 9);
            check("tbl_bcd3", bcd_a, vecs[i].bcd3);
            check("tbl_ovf3", ovf_a, vecs[i].ovf3);
            check("tbl_bcd2", bcd_b, vecs[i].bcd2);
            check("tbl_ovf2", ovf_b, vecs[i].ovf2);
            check("tbl_hex3", hex_a, ref_hex(vecs[i].bin, 3));
            check("tbl_hex2", hex_b, ref_hex(vecs[i].bin, 2));
            check("busy_at_done", busy_a, 0);
            tick;
            check("done_width", done_a, 0);
            check("hold_bcd", bcd_a, vecs[i].bcd3);
        end

        run_a(8'd255, lat);
        check("hex255", hex_a, {7'h24, 7'h12, 7'h12});
        run_a(8'd100, lat);
        check("hex2_dash", hex_b, {7'h3F, 7'h3F});
        run_a(8'd99, lat);
        check("bcd2_99", bcd_b, 8'h99);
        check("ovf2_99", ovf_b, 0);

        // start during busy is ignored; start held into the done cycle is accepted
        tick;
        bin_a = 8'd42; start_a = 1'b1;
        tick;
        start_a = 1'b0;
        check("busy_e0", busy_a, 1);
        repeat (3) tick;
        bin_a = 8'd17; start_a = 1'b1;
        lat = 3;
        while (!done_a && lat < 40) begin
            tick;
            lat++;
        end
        check("ign_lat", lat, 9);
        check("ign_bcd", bcd_a, 12'h042);
        tick;
        start_a = 1'b0;
        check("b2b_busy", busy_a, 1);
        lat = 0;
        while (!done_a && lat < 40) begin
            tick;
            lat++;
        end
        check("b2b_lat", lat, 9);
        check("b2b_bcd", bcd_a, 12'h017);

        // asynchronous reset mid-conversion
        tick;
        bin_a = 8'd200; start_a = 1'b1;
        tick;
        start_a = 1'b0;
        repeat (4) tick;
        resetn = 1'b0;
        #1;
        check("mid_busy", busy_a, 0);
        check("mid_done", done_a, 0);
        check("mid_bcd", bcd_a, 0);
        check("mid_hex", hex_a, ref_hex(0, 3));
        #2 resetn = 1'b1;
        pulses = 0;
        for (int i = 0; i < 15; i++) begin
            tick;
            if (done_a) pulses++;
        end
        check("no_done_after_abort", pulses, 0);
        run_a(8'd7, lat);
        check("post_rst_lat", lat, 9);
        check("post_rst_bcd", bcd_a, 12'h007);

        for (int v = 0; v < 256; v++) begin
            run_a(8'(v), lat);
            check("sweep_lat", lat, 9);
            check_a(v);
        end
        for (int i = 0; i < 40; i++) begin
            int v = int'($urandom_range(255, 0));
            run_a(8'(v), lat);
            check_a(v);
        end

        run_c(16'd65535, lat);
        check("lat16", lat, 17);
        check("bcd5_max", bcd_c, 20'h65535);
        check("ovf5_max", ovf_c, 0);
        check("hex5_max", hex_c, ref_hex(65535, 5));
        for (int i = 0; i < 30; i++) begin
            int v = int'($urandom_range(65535, 0));
            run_c(16'(v), lat);
            check("rnd_lat16", lat, 17);
            check("rnd_bcd5", bcd_c, ref_bcd(v, 5));
            check("rnd_ovf5", ovf_c, 0);
            check("rnd_hex5", hex_c, ref_hex(v, 5));
        end
        run_c(16'd0, lat);
        check("bcd5_zero", bcd_c, 0);
        check("hex5_zero", hex_c, ref_hex(0, 5));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/bin2bcd_seg_seq.md
Name: bin2bcd_seg_seq

Overview:
- Sequential, parametrised binary-to-decimal display driver; successor to the combinational 0–15 two-digit decoder.
- Converts an unsigned WIDTH-bit operand to DIGITS BCD digits using iterative shift-add-3 (double dabble), one bit per clock.
- Drives DIGITS active-low seven-segment displays.
- Sits between switch/counter datapaths and the HEX outputs; uses a start/busy/done handshake.

Parameters:
- WIDTH, 8, binary operand width in bits (range 4..16).
- DIGITS, 3, number of BCD digits and seven-segment displays driven (range 1..5).

Ports:
- clock  input  1  rising-edge clock.
- resetn  input  1  asynchronous active-low reset.
- start  input  1  request conversion of bin; sampled only while idle.
- bin  input  WIDTH  unsigned operand.
- busy  output  1  conversion in progress.
- done  output  1  one-cycle pulse when bcd/hex/ovf update.
- ovf  output  1  operand exceeds 10^DIGITS−1; valid with done, held until the next done.
- bcd  output  4*DIGITS  result; digit i at bits [4i+3:4i], digit 0 = ones.
- hex  output  7*DIGITS  segments, active-low; digit i occupies bits [7i+6:7i]; bit 7i+0 = seg a … bit 7i+6 = seg g.

Behaviour:
- States: IDLE, SHIFT.
- Reset (async, resetn=0): state IDLE; busy=0, done=0, ovf=0, bcd=0; every hex digit shows "0" (a–f lit, g dark).
- Reset mid-conversion: the conversion is aborted and all outputs return to reset values immediately. No done pulse occurs for the aborted operand.
- IDLE with start=1 at edge E0:
  - latch bin into the shift register;
  - clear the BCD accumulator and the internal ovf flag;
  - load the bit counter with WIDTH;
  - go to SHIFT; busy=1 after E0.
- SHIFT, edges E1..E_WIDTH, each edge:
  - for every digit ≥5, add 3 to that digit (all digits in parallel);
  - then shift {accumulator, operand} left by one.
  - A 1 shifted out of the top digit sets internal ovf (sticky for this conversion).
  - The counter decrements once per edge.
- Edge E_WIDTH+1:
  - register bcd, ovf and hex from the final accumulator;
  - done=1 for exactly one cycle; busy=0; return to IDLE.
  - Total latency: WIDTH+1 edges after the sampling edge.
- start while busy=1 is ignored; bin may change freely after E0.
- start=1 in the cycle done=1: accepted, since state is IDLE. Back-to-back conversions every WIDTH+2 cycles.
- Outputs hold their last value between done pulses.
- Overflow: bcd holds the truncated low DIGITS digits; every hex digit shows "-" (only g lit).
- Digit decode for 0–9:
  - 0: abcdef
  - 1: bc
  - 2: abdeg
  - 3: abcdg
  - 4: bcfg
  - 5: acdfg
  - 6: acdefg
  - 7: abc
  - 8: all segments
  - 9: abcdfg
- Codes 10–15 cannot occur; the decoder blanks (all 1s) defensively.
- bin=0 converts normally to all zeros.

Optional Feature:
- Macro: BCD_LEADING_ZERO_BLANK_EN.
- Defined: hex digits above the most significant nonzero digit are blanked (all 1s). Digit 0 is never blanked, so value 0 shows a single "0". This also applies at reset. bcd is unaffected. The overflow dash display overrides blanking.
- Undefined: all digits are displayed, including leading zeros.

Test Plan:
- Defaults (WIDTH=8, DIGITS=3), bin=255, start pulsed at E0 → busy high E0..E9; done high for the single cycle after E9; bcd=12'h255; ovf=0; hex shows "2","5","5".
- Defaults, bin=0 → bcd=12'h000; ovf=0; hex "0","0","0" without the macro, blank/blank/"0" with BCD_LEADING_ZERO_BLANK_EN.
- WIDTH=8, DIGITS=2, bin=100 → ovf=1; bcd=8'h00; both hex digits "-" (g only); bin=99 next → ovf=0, bcd=8'h99.
- Defaults, start re-asserted at E3 with bin=17 during a conversion of 42 → ignored; result bcd=12'h042 at E9. Then start held high through the done cycle → a second conversion of 17 begins; its done follows 9 edges later.
- Defaults, resetn pulled low at E4 of a conversion of 200 → busy=0, done=0, bcd=0 asynchronously; no done pulse afterwards; a new start with bin=7 yields bcd=12'h007.
- WIDTH=16, DIGITS=5, bin=65535 → bcd=20'h65535 after 17 edges; ovf=0; sweep all WIDTH=8 values against a reference model for bcd and hex.
